mac_seq_ctrl: RTL
=================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequencer for a single mac_pe. Takes a start/length command, streams LEN weight/feature
//  pairs from an upstream valid/ready source into the PE, and clears the PE accumulator
//  before each dot product. It waits out the PE latency, then presents the accumulated
//  result on a valid/ready output. Sits between the VIO/host-side stimulus and the PE,
//  in the clk_250m domain.
// PARAMETERS
//  DATA_W   8    width of weight and feature operands
//  ACC_W    32   width of the PE accumulator / result
//  LEN_W    8    width of vec_len; max vector length 2**LEN_W-1
//  PE_LAT   2    cycles from pe_valid high (last pair) until pe_accum includes that pair
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  rst_n       in   1       synchronous, active-low reset
//  start       in   1       command strobe; sampled only in IDLE
//  vec_len     in   LEN_W   number of pairs for this command; latched on accepted start
//  abort       in   1       synchronous cancel of the current command
//  busy        out  1       high in every state except IDLE
//  err_len     out  1       1-cycle pulse: start seen in IDLE with vec_len==0
//  in_valid    in   1       upstream pair valid
//  in_ready    out  1       upstream pair ready (combinational: 1 only in STREAM)
//  in_weight   in   DATA_W  upstream weight
//  in_feature  in   DATA_W  upstream feature
//  pe_rst_n    out  1       to mac_pe rst_n; low in CLEAR, in ABORT and while rst_n low
//  pe_weight   out  DATA_W  to mac_pe weight (registered)
//  pe_feature  out  DATA_W  to mac_pe feature_in (registered)
//  pe_valid    out  1       to mac_pe valid_in (registered)
//  pe_accum    in   ACC_W   from mac_pe accum_out
//  res_valid   out  1       result valid; held until res_ready
//  res_ready   in   1       downstream accept
//  res_data    out  ACC_W   captured accumulator; stable while res_valid
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge)
//   - state=IDLE; busy=0; err_len=0; pe_valid=0; pe_weight=pe_feature=0.
//   - res_valid=0; res_data=0; counters=0.
//   - pe_rst_n=0 combinationally while rst_n=0.
//   - Reset mid-command discards all progress; no result is produced.
//  FSM
//   - IDLE:
//     - start & vec_len!=0 -> CLEAR; latch len.
//     - start & vec_len==0 -> stay IDLE; err_len=1 next cycle.
//   - CLEAR: exactly 1 cycle with pe_rst_n=0, cnt=0 -> STREAM.
//   - STREAM:
//     - in_ready=1. Each in_valid&in_ready cycle registers the operands into pe_weight/pe_feature
//       and sets pe_valid=1 in the next cycle.
//     - A cycle with no handshake gives pe_valid=0 next cycle; operands hold their last value.
//     - The handshake with cnt==len-1 -> DRAIN; otherwise cnt++.
//   - DRAIN:
//     - dcnt counts PE_LAT+1 cycles from entry, which covers the final registered pe_valid plus PE_LAT.
//     - Then capture res_data<=pe_accum and set res_valid=1 -> HOLD.
//   - HOLD: res_valid=1, res_data stable. res_valid&res_ready -> IDLE; res_valid=0 next cycle.
//   - ABORT (any non-IDLE state with abort=1):
//     - Next state is IDLE; pe_valid=0; res_valid=0; the result is dropped.
//     - pe_rst_n=0 for 1 cycle to scrub partial accumulation.
//  Rules
//   - start while busy is ignored, not queued.
//   - abort in IDLE has no effect.
//   - abort and start in the same IDLE cycle: start wins.
//   - abort has priority over a STREAM handshake in the same cycle; that pair is not consumed,
//     so in_ready=0 when abort=1.
//   - Controller does no arithmetic on pe_accum; it passes bits through. Sign is owned by the PE.
//   - Throughput: no bubbles with in_valid held high. len pairs take len cycles of STREAM.
//   - Start-to-res_valid = 1(CLEAR)+len+PE_LAT+2 cycles.
//   - Back-to-back: a new start is accepted in the cycle after the HOLD handshake.
//   - len = 2**LEN_W-1 must work with no counter wrap.
// TESTING
//  1 len=4, w={1,2,3,4}, f={5,6,7,8}, in_valid held 1, res_ready=1
//    -> res_data=70; res_valid 4+PE_LAT+3 cycles after start.
//  2 Same vectors, in_valid toggled 1,0,0,1,0,1,1
//    -> pe_valid mirrors the handshakes delayed by 1 cycle; res_data=70.
//  3 Two commands back-to-back: {2,3}x{4,5} then len=1 {7}x{9}
//    -> results 23 then 63; the second is not polluted (CLEAR pulse seen).
//  4 start with vec_len=0 -> err_len single pulse, busy stays 0, no PE activity.
//    Also: start pulsed during STREAM is ignored.
//  5 len=8, abort after 3 pairs -> IDLE next cycle, pe_rst_n low 1 cycle, no res_valid.
//    A following len=1 {2}x{3} command gives 6.
//  6 rst_n low during HOLD with res_ready=0 -> res_valid=0, busy=0, pe_rst_n=0 while in reset.
//    res_ready held 0 for 10 cycles in HOLD -> res_data stable throughout.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// ============================================================================
//  Module      : mac_seq_ctrl
//  Description : Command sequencer for one mac_pe. It clears the accumulator,
//                streams LEN operand pairs, drains the PE pipeline and
//                presents the result on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8,
    parameter int PE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              abort,
    output logic              busy,
    output logic              err_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] in_feature,
    output logic              pe_rst_n,
    output logic [DATA_W-1:0] pe_weight,
    output logic [DATA_W-1:0] pe_feature,
    output logic              pe_valid,
    input  logic [ACC_W-1:0]  pe_accum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    localparam int DCNT_W = $clog2(PE_LAT + 2);
    localparam logic [DCNT_W-1:0] c_drain_last = DCNT_W'(PE_LAT);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_clear  = 3'd1;
    localparam logic [2:0] c_stream = 3'd2;
    localparam logic [2:0] c_drain  = 3'd3;
    localparam logic [2:0] c_hold   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_pe_valid;
    logic [DATA_W-1:0] r_pe_weight;
    logic [DATA_W-1:0] r_pe_feature;
    logic              r_res_valid;
    logic [ACC_W-1:0]  r_res_data;
    logic              r_err_len;

    logic w_busy;
    logic w_abort;
    logic w_hs;
    logic w_start_ok;
    logic w_last;
    logic w_drain_done;

    assign w_busy       = (r_state != c_idle);
    assign w_abort      = abort & w_busy;
    assign w_start_ok   = (r_state == c_idle) & start & (vec_len != '0);
    assign w_hs         = in_valid & in_ready;
    assign w_last       = (r_cnt == (r_len - LEN_W'(1)));
    assign w_drain_done = (r_dcnt == c_drain_last);

    assign busy       = w_busy;
    assign in_ready   = (r_state == c_stream) & ~abort;
    // Accumulator is scrubbed before every command and on cancel
    assign pe_rst_n   = rst_n & (r_state != c_clear) & ~w_abort;
    assign err_len    = r_err_len;
    assign pe_valid   = r_pe_valid;
    assign pe_weight  = r_pe_weight;
    assign pe_feature = r_pe_feature;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:   if (w_start_ok) w_next_state = c_clear;
            c_clear:  w_next_state = c_stream;
            c_stream: if (w_hs && w_last) w_next_state = c_drain;
            c_drain:  if (w_drain_done) w_next_state = c_hold;
            c_hold:   if (res_ready) w_next_state = c_idle;
            default:  w_next_state = c_idle;
        endcase
        if (w_abort) begin
            w_next_state = c_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_dcnt       <= '0;
            r_pe_valid   <= 1'b0;
            r_pe_weight  <= '0;
            r_pe_feature <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_err_len    <= 1'b0;
        end else begin
            r_err_len  <= (r_state == c_idle) & start & (vec_len == '0);
            r_pe_valid <= w_hs;
            if (w_hs) begin
                r_pe_weight  <= in_weight;
                r_pe_feature <= in_feature;
            end
            if (w_start_ok) begin
                r_len <= vec_len;
            end
            // Counter stops at len-1 so the maximum length never wraps
            if (r_state == c_clear) begin
                r_cnt <= '0;
            end else if (w_hs && !w_last) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if ((r_state == c_drain) && !w_abort) begin
                r_dcnt <= r_dcnt + DCNT_W'(1);
            end else begin
                r_dcnt <= '0;
            end
            if (w_abort) begin
                r_res_valid <= 1'b0;
            end else if ((r_state == c_drain) && w_drain_done) begin
                r_res_data  <= pe_accum;
                r_res_valid <= 1'b1;
            end else if ((r_state == c_hold) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
